// File: rtl/ntt_twiddle_seq.sv
// ntt_twiddle_seq: walks the NTT twiddle ROM in Kyber order and streams each twiddle once per butterfly
module ntt_twiddle_seq #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    output logic [6:0]            rom_addr,
    output logic                  rom_wr_ena,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] tw_data,
    output logic                  tw_valid,
    input  logic                  tw_ready,
    output logic [2:0]            tw_stage,
    output logic                  tw_last,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, EMIT, DONE} state_t;
    state_t state, state_n;
    logic       mode_r;
    logic [6:0] k, rep, k_n;
    logic [7:0] len;
    logic [2:0] stage;
    logic       hs, exhausted, last, stage_up;
    assign hs        = (state == EMIT) && tw_ready;
    assign exhausted = {1'b0, rep} == len - 8'd1;
    assign last      = exhausted && (k == (mode_r ? 7'd1 : 7'd127));
    assign k_n       = mode_r ? k - 7'd1 : k + 7'd1;
    // forward stages begin at powers of two, inverse stages at 2^n - 1
    assign stage_up  = mode_r ? ((k_n & (k_n + 7'd1)) == 7'd0) : ((k_n & (k_n - 7'd1)) == 7'd0);
    assign rom_wr_ena = 1'b0;
    assign tw_valid   = state == EMIT;
    assign tw_stage   = stage;
    assign tw_last    = (state == EMIT) && last;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    // next-state: one fetch/latch pair per twiddle, then hold it until exhausted
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FETCH : IDLE;
            FETCH:   state_n = LATCH;
            LATCH:   state_n = EMIT;
            EMIT:    state_n = (hs && exhausted) ? (last ? DONE : FETCH) : EMIT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // state, walk counters, ROM address and captured twiddle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            k        <= 7'd0;
            rep      <= 7'd0;
            len      <= 8'd0;
            stage    <= 3'd0;
            rom_addr <= 7'd0;
            tw_data  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                mode_r   <= mode;
                k        <= mode ? 7'd127 : 7'd1;
                rom_addr <= mode ? 7'd127 : 7'd1;
                len      <= mode ? 8'd2 : 8'd128;
                stage    <= 3'd0;
                rep      <= 7'd0;
            end
            if (state == LATCH) tw_data <= rom_data;
            if (hs) begin
                rep <= exhausted ? 7'd0 : rep + 7'd1;
                if (exhausted && !last) begin
                    k        <= k_n;
                    rom_addr <= k_n;
                    if (stage_up) begin
                        stage <= stage + 3'd1;
                        len   <= mode_r ? len << 1 : len >> 1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ntt_twiddle_seq.sv
// tb_ntt_twiddle_seq: self-checking bench with a ROM model and an ordered twiddle scoreboard
module tb_ntt_twiddle_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [6:0]  rom_addr;
    logic        rom_wr_ena;
    logic [11:0] rom_data = 12'd0;
    logic [11:0] tw_data;
    logic        tw_valid;
    logic        tw_ready = 1'b1;
    logic [2:0]  tw_stage;
    logic        tw_last;
    logic        busy;
    logic        done;

    typedef struct {
        logic [11:0] d;
        logic [2:0]  s;
        logic        l;
    } exp_t;

    logic [11:0] rom [128];
    exp_t        q[$];
    int          checks = 0;
    int          fails = 0;
    int          hs_cnt = 0;
    int          gap = 0;
    logic        m_mode = 1'b0;
    logic        rnd = 1'b0;
    logic        last_pend = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic [11:0] p_data;
    logic [2:0]  p_stage;
    logic        p_last;

    ntt_twiddle_seq #(.DATA_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .rom_addr(rom_addr), .rom_wr_ena(rom_wr_ena), .rom_data(rom_data),
        .tw_data(tw_data), .tw_valid(tw_valid), .tw_ready(tw_ready),
        .tw_stage(tw_stage), .tw_last(tw_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        #1;
        tw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input logic m);
        exp_t e;
        q.delete();
        for (int s = 0; s < 7; s++) begin
            if (!m) begin
                for (int kk = 1 << s; kk < (2 << s); kk++)
                    for (int r = 0; r < (128 >> s); r++) q.push_back('{rom[kk], 3'(s), 1'b0});
            end else begin
                for (int kk = (128 >> s) - 1; kk >= (64 >> s); kk--)
                    for (int r = 0; r < (2 << s); r++) q.push_back('{rom[kk], 3'(s), 1'b0});
            end
        end
        e = q.pop_back();
        e.l = 1'b1;
        q.push_back(e);
    endtask

    task automatic chk_reset();
        chk("rst_valid", int'(tw_valid), 0);
        chk("rst_data", int'(tw_data), 0);
        chk("rst_stage", int'(tw_stage), 0);
        chk("rst_last", int'(tw_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_wr", int'(rom_wr_ena), 0);
    endtask

    task automatic start_run(input logic m);
        fill(m);
        m_mode = m;
        @(posedge clk); #1;
        start = 1'b1;
        mode = m;
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~m;
        chk("start_busy", int'(busy), 1);
        chk("start_addr", int'(rom_addr), m ? 127 : 1);
    endtask

    task automatic wait_done();
        logic seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", int'(seen), 1);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic lit(input string name, input int d, input int s);
        chk({name, "_data"}, int'(tw_data), d);
        chk({name, "_stage"}, int'(tw_stage), s);
    endtask

    // per-cycle scoreboard, protocol and timing checks
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            last_pend = 1'b0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            gap = 0;
            hs_cnt = 0;
        end else begin
            chk("wr_ena", int'(rom_wr_ena), 0);
            chk("done_pulse", int'(done), int'(last_pend));
            last_pend = 1'b0;
            if (busy) chk("addr_nonzero", int'(rom_addr != 7'd0), 1);
            if (!busy) begin
                gap = 0;
                hs_cnt = 0;
            end else if (!tw_valid) gap++;
            if (tw_valid && !prev_valid) begin
                chk("gap", gap, 2);
                gap = 0;
            end
            if (prev_stall) begin
                chk("stall_valid", int'(tw_valid), 1);
                chk("stall_data", int'(tw_data), int'(p_data));
                chk("stall_stage", int'(tw_stage), int'(p_stage));
                chk("stall_last", int'(tw_last), int'(p_last));
            end
            if (tw_valid && tw_ready) begin
                if (q.size() == 0) chk("extra_handshake", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("sb_data", int'(tw_data), int'(e.d));
                    chk("sb_stage", int'(tw_stage), int'(e.s));
                    chk("sb_last", int'(tw_last), int'(e.l));
                    last_pend = e.l;
                end
                if (!m_mode) begin
                    if (hs_cnt == 0) lit("fwd_first", 872, 0);
                    if (hs_cnt == 128) lit("fwd_k2", 2167, 1);
                    if (hs_cnt == 192) lit("fwd_k3", 2144, 1);
                    if (hs_cnt == 894 || hs_cnt == 895) lit("fwd_k127", 1285, 6);
                end else begin
                    if (hs_cnt == 0 || hs_cnt == 1) lit("inv_k127", 1285, 0);
                    if (hs_cnt == 2 || hs_cnt == 3) lit("inv_k126", 3058, 0);
                    if (hs_cnt == 768 || hs_cnt == 895) lit("inv_k1", 872, 6);
                end
                if (hs_cnt == 895) chk("lit_last", int'(tw_last), 1);
                hs_cnt++;
            end
            prev_stall = tw_valid && !tw_ready;
            prev_valid = tw_valid;
            p_data = tw_data;
            p_stage = tw_stage;
            p_last = tw_last;
        end
    end

    initial begin
        #(50000 * 10);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hit;
        for (int i = 0; i < 128; i++) rom[i] = 12'((i * 37 + 5) % 4096);
        rom[1] = 12'd872;
        rom[2] = 12'd2167;
        rom[3] = 12'd2144;
        rom[126] = 12'd3058;
        rom[127] = 12'd1285;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset();
        start_run(1'b0);
        wait_done();
        start_run(1'b1);
        wait_done();
        rnd = 1'b1;
        start_run(1'b0);
        repeat (300) @(posedge clk);
        #1;
        start = 1'b1;
        mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'b0;
        wait_done();
        rnd = 1'b0;
        start_run(1'b0);
        wait_done();
        start_run(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = hs_cnt >= 673;
        end
        chk("reach_k40", int'(hit), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset();
        start_run(1'b0);
        wait_done();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
